// File: rtl/modmul_seq_3187.sv
// ============================================================================
// modmul_seq_3187 : bit-serial interleaved (Blakley) modular multiplier,
//                   dout_r = (din_a * din_b) mod Q, one multiplier bit/cycle.
// Optional feature macro: MODMUL_RANGE_CHECK_EN (operand pre-reduce + err).
// Revision: 1.0
// ============================================================================
`default_nettype none

module modmul_seq_3187 #(
    parameter int Q  = 3187,
    parameter int W  = 12,
    parameter int AW = W + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din_a,
    input  logic [W-1:0] din_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout_r
`ifdef MODMUL_RANGE_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int             c_CW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(W - 1);
    localparam logic [AW-1:0]   c_Q       = AW'(Q);
    localparam logic [AW-1:0]   c_Q2      = AW'(2 * Q);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     acc_d;
    logic [c_CW-1:0]   cnt_q;

    logic [AW-1:0]     w_t;
    logic [AW-1:0]     w_t_m1;
    logic [AW-1:0]     w_t_m2;
    logic              w_ge1;
    logic              w_ge2;
    logic [W-1:0]      w_a_in;
    logic [W-1:0]      w_b_in;

    // acc < Q and a < Q keep t below 3Q, so at most two subtractions of Q.
    always_comb begin
        w_t    = (acc_q << 1) + (b_q[cnt_q] ? AW'(a_q) : '0);
        w_t_m1 = w_t - c_Q;
        w_t_m2 = w_t - c_Q2;
        w_ge1  = (w_t >= c_Q);
        w_ge2  = (w_t >= c_Q2);
        if (w_ge2)
            acc_d = w_t_m2;
        else if (w_ge1)
            acc_d = w_t_m1;
        else
            acc_d = w_t;
    end

`ifdef MODMUL_RANGE_CHECK_EN
    logic w_a_big;
    logic w_b_big;
    logic err_pend_q;

    // 2^W - 1 < 2Q, so one subtraction always lands the operand below Q.
    always_comb begin
        w_a_big = (din_a >= W'(Q));
        w_b_big = (din_b >= W'(Q));
        w_a_in  = w_a_big ? (din_a - W'(Q)) : din_a;
        w_b_in  = w_b_big ? (din_b - W'(Q)) : din_b;
    end
`else
    assign w_a_in = din_a;
    assign w_b_in = din_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dout_r    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`ifdef MODMUL_RANGE_CHECK_EN
            err       <= 1'b0;
            err_pend_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= w_a_in;
                        b_q      <= w_b_in;
                        acc_q    <= '0;
                        cnt_q    <= c_CNT_MAX;
                        in_ready <= 1'b0;
                        state_q  <= S_BUSY;
`ifdef MODMUL_RANGE_CHECK_EN
                        err_pend_q <= w_a_big | w_b_big;
`endif
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        dout_r    <= acc_d[W-1:0];
                        out_valid <= 1'b1;
                        state_q   <= S_DONE;
`ifdef MODMUL_RANGE_CHECK_EN
                        err       <= err_pend_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - c_CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= S_IDLE;
`ifdef MODMUL_RANGE_CHECK_EN
                        err       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_modmul_seq_3187.sv
// ============================================================================
// tb_modmul_seq_3187 : directed self-checking bench for modmul_seq_3187.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_modmul_seq_3187;

    localparam int Q = 3187;
    localparam int W = 12;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] din_a     = '0;
    logic [W-1:0] din_b     = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] dout_r;
`ifdef MODMUL_RANGE_CHECK_EN
    logic         err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;

    modmul_seq_3187 #(.Q(Q), .W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .din_b     (din_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_r    (dout_r)
`ifdef MODMUL_RANGE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transaction; hold_test keeps out_ready low 20 cycles in DONE and
    // keeps in_valid asserted with different operands while busy.
    task automatic run_op(input int a, input int b, input int exp, input bit hold_test);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("idle_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        din_a     = W'(a);
        din_b     = W'(b);
        in_valid  = 1'b1;
        out_ready = !hold_test;
        @(posedge clk); #1;
        check_eq("accept_drop", 32'(in_ready), 32'd0);
        if (hold_test) begin
            din_a = W'(5);
            din_b = W'(5);
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'd12);
        check_eq("result", 32'(dout_r), 32'(exp));
        check_eq("below_q", 32'(dout_r < W'(Q)), 32'd1);
`ifdef MODMUL_RANGE_CHECK_EN
        check_eq("err", 32'(err), 32'(exp_err));
`endif
        if (hold_test) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'(dout_r), 32'(exp));
                check_eq("hold_inrdy", 32'(in_ready), 32'd0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("hs_valid", 32'(out_valid), 32'd0);
        check_eq("hs_inrdy", 32'(in_ready), 32'd1);
`ifdef MODMUL_RANGE_CHECK_EN
        check_eq("hs_err", 32'(err), 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_inrdy", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_dout", 32'(dout_r), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(100, 100, 439, 1'b0);
        run_op(3186, 3186, 1, 1'b0);
        run_op(2, 1594, 1, 1'b0);
        run_op(0, 2500, 0, 1'b0);
        run_op(2500, 0, 0, 1'b0);
        run_op(1234, 2, 2468, 1'b1);

        for (int a = 0; a < Q; a += 4)
            run_op(a, 2, (a * 2) % Q, 1'b0);
        run_op(3186, 2, 3185, 1'b0);
        for (int a = 0; a < Q; a++)
            run_op(a, 3186, (a * 3186) % Q, 1'b0);

        // Asynchronous abort five cycles into BUSY.
        @(negedge clk);
        din_a    = W'(1000);
        din_b    = W'(1000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_inrdy", 32'(in_ready), 32'd1);
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_dout", 32'(dout_r), 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check_eq("abort_novalid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(7, 9, 63, 1'b0);

`ifdef MODMUL_RANGE_CHECK_EN
        exp_err = 1;
        run_op(3190, 5, 15, 1'b0);
        exp_err = 0;
        run_op(3, 5, 15, 1'b0);
        exp_err = 1;
        run_op(4095, 4095, (908 * 908) % Q, 1'b0);
        exp_err = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
